game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter POWER_TICKS, default 300: ticks Pac-Man stays powered after eating fruit.
REQ-002 SHALL have parameter RESPAWN_TICKS, default 600: ticks before an eaten fruit reappears.
REQ-003 SHALL have port collClk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: start or restart request, level-sampled.
REQ-006 SHALL have port tick, input, 1: one-cycle frame-rate enable for timers.
REQ-007 SHALL have port collision, input, 44: per-pellet Pac-Man hit, gated by blockEn.
REQ-008 SHALL have port fruitCollisionPacman, input, 3: per-fruit Pac-Man hit.
REQ-009 SHALL have port fruitCollisionGhost, input, 3: per-fruit ghost hit.
REQ-010 SHALL have port PlayerCollision, input, 1: ghost touches Pac-Man.
REQ-011 SHALL have port blockEn, output, 44: pellet present mask, fed to the collision block.
REQ-012 SHALL have port fruitEn, output, 3: fruit present mask, fed to the collision block.
REQ-013 SHALL have port score, output, 6: pellets eaten this round, 0..44.
REQ-014 SHALL have port power, output, 1: high in state POWER.
REQ-015 SHALL have port state, output, 3: current FSM state encoding.
REQ-016 SHALL have port pacWin, output, 1: high in state PAC_WIN.
REQ-017 SHALL have port ghostWin, output, 1: high in state GHOST_WIN.
REQ-018 SHALL have port rstPos, output, 1: one-cycle pulse that returns sprites to home positions.

Function
REQ-019 The FSM SHALL have states IDLE=0, PLAY=1, POWER=2, PAC_WIN=3, GHOST_WIN=4.
REQ-020 In IDLE, blockEn SHALL be all ones, fruitEn 3'b111, score 0, and all timers 0.
REQ-021 IDLE SHALL go to PLAY when start=1, with rstPos pulsed in that same cycle.
REQ-022 In PLAY or POWER, any bit i with collision[i]&blockEn[i] SHALL clear blockEn[i] on the next edge.
REQ-023 On that edge, score SHALL increase by the popcount of the cleared bits; multiple bits in one cycle are all counted.
REQ-024 In PLAY or POWER, for fruit j with fruitEn[j]=1 and either fruit collision asserted, fruitEn[j] SHALL clear and respawn counter j SHALL load RESPAWN_TICKS.
REQ-025 If Pac-Man and the ghost hit fruit j in the same cycle, Pac-Man SHALL take priority.
REQ-026 A Pac-Man fruit hit SHALL enter POWER and load the power timer with POWER_TICKS.
REQ-027 A Pac-Man fruit hit while already in POWER SHALL reload the power timer to POWER_TICKS.
REQ-028 A ghost fruit hit SHALL only remove the fruit; it SHALL NOT change state.
REQ-029 Each nonzero respawn counter SHALL decrement on tick; on the tick it reaches 0, fruitEn[j] SHALL be set again.
REQ-030 The power timer SHALL decrement on tick; POWER SHALL return to PLAY on the tick it reaches 0.
REQ-031 PLAY with PlayerCollision=1 SHALL go to GHOST_WIN; this takes priority over a same-cycle last pellet.
REQ-032 POWER with PlayerCollision=1 SHALL go to PAC_WIN.
REQ-033 PLAY or POWER SHALL go to PAC_WIN when blockEn becomes all zero, i.e. score reaches 44.
REQ-034 PAC_WIN and GHOST_WIN SHALL freeze blockEn, fruitEn, score and all timers.
REQ-035 PAC_WIN and GHOST_WIN SHALL go to IDLE on start=1; IDLE then re-arms and waits for start.
REQ-036 Collision inputs SHALL be ignored in IDLE, PAC_WIN and GHOST_WIN.
REQ-037 Timer widths SHALL be $clog2(param+1); parameter values of 0 are illegal.

Reset
REQ-038 rst=0 SHALL asynchronously force state IDLE, blockEn all ones, fruitEn 3'b111, score 0, all timers 0, power/pacWin/ghostWin/rstPos 0.
REQ-039 Reset asserted mid-round SHALL discard round progress; start is honoured on the first edge after reset is released.

Structure
REQ-040 A shared package SHALL hold the state encodings, NUM_BLOCKS=44 and NUM_FRUIT=3.
REQ-041 One sub-module, fruit_respawn, SHALL implement a single fruit's enable flag and respawn counter, instantiated ×3.

Verification
REQ-042 Reset, then start=1 for 1 cycle -> state=1, rstPos pulses once, blockEn=44'hFFF_FFFF_FFFF, score=0.
REQ-043 PLAY, collision[0] and collision[43] both set for one cycle -> blockEn bits 0 and 43 clear, score=2; re-asserting them leaves score at 2.
REQ-044 PLAY, fruitCollisionPacman[1]=1 with POWER_TICKS=3 -> state=2, fruitEn=3'b101; after 3 ticks -> state=1.
REQ-045 fruitCollisionPacman[0] and fruitCollisionGhost[0] in the same cycle -> POWER entered, fruitEn[0]=0; RESPAWN_TICKS=4 -> fruitEn[0]=1 on the 4th tick.
REQ-046 PLAY, PlayerCollision=1 in the same cycle as the 44th pellet -> GHOST_WIN, ghostWin=1; then start=1 -> IDLE with blockEn all ones.
REQ-047 POWER, PlayerCollision=1 -> PAC_WIN; rst=0 asserted mid-POWER -> immediate IDLE with all outputs at reset values.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the Pac-Man game controller: state encodings,
// playfield sizes and a pellet population counter.
package game_ctrl_pkg;

    localparam int NUM_BLOCKS = 44;
    localparam int NUM_FRUIT  = 3;
    localparam int SCORE_W    = $clog2(NUM_BLOCKS + 1);

    localparam logic [NUM_BLOCKS-1:0] ALL_BLOCKS = '1;
    localparam logic [NUM_FRUIT-1:0]  ALL_FRUIT  = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        POWER     = 3'd2,
        PAC_WIN   = 3'd3,
        GHOST_WIN = 3'd4
    } gameState_t;

    // Several pellets can vanish on the same edge, so the score step is a popcount.
    function automatic logic [SCORE_W-1:0] countOnes(input logic [NUM_BLOCKS-1:0] bits);
        logic [SCORE_W-1:0] total;
        total = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            total = total + {{(SCORE_W-1){1'b0}}, bits[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/fruit_respawn.sv
// One fruit's presence flag plus the countdown that brings it back after it
// has been eaten by either Pac-Man or a ghost.
module fruit_respawn
    import game_ctrl_pkg::*;
#(
    parameter int RESPAWN_TICKS = 600
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic run,
    input  logic rearm,
    input  logic hit,
    output logic present
);

    localparam int RESPAWN_W = $clog2(RESPAWN_TICKS + 1);

    logic [RESPAWN_W-1:0] respawnCount;

    // The counter only runs during live play, so a finished round freezes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            present      <= 1'b1;
            respawnCount <= '0;
        end else if (rearm) begin
            present      <= 1'b1;
            respawnCount <= '0;
        end else if (run) begin
            if (present && hit) begin
                present      <= 1'b0;
                respawnCount <= RESPAWN_W'(RESPAWN_TICKS);
            end else if (tick && (respawnCount != '0)) begin
                respawnCount <= respawnCount - RESPAWN_W'(1);
                if (respawnCount == RESPAWN_W'(1)) begin
                    present <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Round controller for the Pac-Man game: tracks pellets, fruit, score, the
// power-up timer and the win/lose state machine.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int POWER_TICKS   = 300,
    parameter int RESPAWN_TICKS = 600
) (
    input  logic                  collClk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  tick,
    input  logic [NUM_BLOCKS-1:0] collision,
    input  logic [NUM_FRUIT-1:0]  fruitCollisionPacman,
    input  logic [NUM_FRUIT-1:0]  fruitCollisionGhost,
    input  logic                  PlayerCollision,
    output logic [NUM_BLOCKS-1:0] blockEn,
    output logic [NUM_FRUIT-1:0]  fruitEn,
    output logic [SCORE_W-1:0]    score,
    output logic                  power,
    output logic [2:0]            state,
    output logic                  pacWin,
    output logic                  ghostWin,
    output logic                  rstPos
);

    localparam int POWER_W = $clog2(POWER_TICKS + 1);

    gameState_t             currentState;
    gameState_t             nextState;
    logic [NUM_BLOCKS-1:0]  eaten;
    logic [NUM_BLOCKS-1:0]  blockEnNext;
    logic [SCORE_W-1:0]     scoreNext;
    logic [POWER_W-1:0]     powerTimer;
    logic [POWER_W-1:0]     powerTimerNext;
    logic                   running;
    logic                   rearm;
    logic                   pacFruitHit;
    logic                   allEaten;

    // Collisions only count while a round is live; IDLE and a restart from a
    // finished round both restore the full board.
    assign running     = (currentState == PLAY) || (currentState == POWER);
    assign rearm       = (currentState == IDLE) ||
                         (((currentState == PAC_WIN) || (currentState == GHOST_WIN)) && start);
    assign eaten       = running ? (collision & blockEn) : '0;
    assign pacFruitHit = running && (|(fruitCollisionPacman & fruitEn));
    assign allEaten    = ~|(blockEn & ~eaten);

    always_comb begin
        nextState = currentState;
        case (currentState)
            IDLE: begin
                if (start) nextState = PLAY;
            end
            PLAY: begin
                if (PlayerCollision)  nextState = GHOST_WIN;
                else if (allEaten)    nextState = PAC_WIN;
                else if (pacFruitHit) nextState = POWER;
            end
            POWER: begin
                if (PlayerCollision || allEaten) begin
                    nextState = PAC_WIN;
                end else if (!pacFruitHit && tick && (powerTimer == POWER_W'(1))) begin
                    nextState = PLAY;
                end
            end
            PAC_WIN, GHOST_WIN: begin
                if (start) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // A fresh fruit hit always wins over the countdown, so staying powered
    // up never expires on the same edge as a reload.
    always_comb begin
        blockEnNext    = blockEn;
        scoreNext      = score;
        powerTimerNext = powerTimer;
        if (rearm) begin
            blockEnNext    = ALL_BLOCKS;
            scoreNext      = '0;
            powerTimerNext = '0;
        end else if (running) begin
            blockEnNext = blockEn & ~eaten;
            scoreNext   = score + countOnes(eaten);
            if ((nextState == POWER) && pacFruitHit) begin
                powerTimerNext = POWER_W'(POWER_TICKS);
            end else if ((currentState == POWER) && tick && (powerTimer != '0)) begin
                powerTimerNext = powerTimer - POWER_W'(1);
            end
        end
    end

    always_ff @(posedge collClk or negedge rst) begin
        if (!rst) begin
            currentState <= IDLE;
            blockEn      <= ALL_BLOCKS;
            score        <= '0;
            powerTimer   <= '0;
            rstPos       <= 1'b0;
        end else begin
            currentState <= nextState;
            blockEn      <= blockEnNext;
            score        <= scoreNext;
            powerTimer   <= powerTimerNext;
            rstPos       <= (currentState == IDLE) && start;
        end
    end

    for (genvar j = 0; j < NUM_FRUIT; j++) begin : gFruit
        fruit_respawn #(
            .RESPAWN_TICKS(RESPAWN_TICKS)
        ) uFruit (
            .clk     (collClk),
            .rst     (rst),
            .tick    (tick),
            .run     (running),
            .rearm   (rearm),
            .hit     (fruitCollisionPacman[j] | fruitCollisionGhost[j]),
            .present (fruitEn[j])
        );
    end

    assign state    = currentState;
    assign power    = (currentState == POWER);
    assign pacWin   = (currentState == PAC_WIN);
    assign ghostWin = (currentState == GHOST_WIN);

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: each step pushes the expected output
// snapshot, and each scenario task compares it with what the DUT produced.
module tb_game_ctrl;

    logic        collClk;
    logic        rst;
    logic        start;
    logic        tick;
    logic [43:0] collision;
    logic [2:0]  fruitCollisionPacman;
    logic [2:0]  fruitCollisionGhost;
    logic        PlayerCollision;
    logic [43:0] blockEn;
    logic [2:0]  fruitEn;
    logic [5:0]  score;
    logic        power;
    logic [2:0]  state;
    logic        pacWin;
    logic        ghostWin;
    logic        rstPos;

    typedef struct packed {
        logic [2:0]  st;
        logic [43:0] blk;
        logic [2:0]  fr;
        logic [5:0]  sc;
        logic        pw;
        logic        pwin;
        logic        gwin;
        logic        rp;
    } snap_t;

    typedef struct {
        string name;
        snap_t snap;
    } entry_t;

    entry_t expQ[$];
    snap_t  obsQ[$];

    int passCount  = 0;
    int checkCount = 0;

    logic [2:0]  mState;
    logic [43:0] mBlock;
    logic [2:0]  mFruit;
    logic [5:0]  mScore;
    logic        mRstPos;

    game_ctrl #(
        .POWER_TICKS   (3),
        .RESPAWN_TICKS (4)
    ) dut (
        .collClk              (collClk),
        .rst                  (rst),
        .start                (start),
        .tick                 (tick),
        .collision            (collision),
        .fruitCollisionPacman (fruitCollisionPacman),
        .fruitCollisionGhost  (fruitCollisionGhost),
        .PlayerCollision      (PlayerCollision),
        .blockEn              (blockEn),
        .fruitEn              (fruitEn),
        .score                (score),
        .power                (power),
        .state                (state),
        .pacWin               (pacWin),
        .ghostWin             (ghostWin),
        .rstPos               (rstPos)
    );

    initial collClk = 1'b0;
    always #5 collClk = ~collClk;

    function automatic snap_t observe();
        return '{state, blockEn, fruitEn, score, power, pacWin, ghostWin, rstPos};
    endfunction

    function automatic snap_t model();
        return '{mState, mBlock, mFruit, mScore, (mState == 3'd2), (mState == 3'd3),
                 (mState == 3'd4), mRstPos};
    endfunction

    task automatic modelReset();
        mState  = 3'd0;
        mBlock  = '1;
        mFruit  = 3'b111;
        mScore  = 6'd0;
        mRstPos = 1'b0;
    endtask

    task automatic eat(input logic [43:0] col);
        mBlock = mBlock & ~col;
        mScore = 6'(44 - $countones(mBlock));
    endtask

    // Drives one cycle of inputs, records the expectation, then samples after the edge.
    task automatic applyStimulus(input string name, input logic [43:0] col,
                                 input logic [2:0] fp, input logic [2:0] fg,
                                 input logic pc, input logic st, input logic tk);
        collision            = col;
        fruitCollisionPacman = fp;
        fruitCollisionGhost  = fg;
        PlayerCollision      = pc;
        start                = st;
        tick                 = tk;
        expQ.push_back('{name, model()});
        @(posedge collClk);
        #1;
        obsQ.push_back(observe());
        collision            = '0;
        fruitCollisionPacman = '0;
        fruitCollisionGhost  = '0;
        PlayerCollision      = 1'b0;
        start                = 1'b0;
        tick                 = 1'b0;
    endtask

    task automatic test_reset();
        entry_t e;
        snap_t  o;
        start = 1'b1;
        @(posedge collClk);
        #1;
        expQ.push_back('{"reset_hold", model()});
        obsQ.push_back(observe());
        start = 1'b0;
        rst   = 1'b1;
        applyStimulus("idle_wait", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkCount++;
            if (o !== e.snap) $display("[TB] FAIL %s: got st=%0d blk=%h fr=%b sc=%0d flags=%b, expected st=%0d blk=%h fr=%b sc=%0d flags=%b", e.name, o.st, o.blk, o.fr, o.sc, {o.pw, o.pwin, o.gwin, o.rp}, e.snap.st, e.snap.blk, e.snap.fr, e.snap.sc, {e.snap.pw, e.snap.pwin, e.snap.gwin, e.snap.rp});
            else passCount++;
        end
    endtask

    task automatic test_start();
        entry_t e;
        snap_t  o;
        mState  = 3'd1;
        mRstPos = 1'b1;
        applyStimulus("start", '0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        mRstPos = 1'b0;
        applyStimulus("rstpos_drop", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkCount++;
            if (o !== e.snap) $display("[TB] FAIL %s: got st=%0d blk=%h fr=%b sc=%0d flags=%b, expected st=%0d blk=%h fr=%b sc=%0d flags=%b", e.name, o.st, o.blk, o.fr, o.sc, {o.pw, o.pwin, o.gwin, o.rp}, e.snap.st, e.snap.blk, e.snap.fr, e.snap.sc, {e.snap.pw, e.snap.pwin, e.snap.gwin, e.snap.rp});
            else passCount++;
        end
    endtask

    task automatic test_pellets();
        entry_t      e;
        snap_t       o;
        logic [43:0] col;
        col = (44'd1 << 0) | (44'd1 << 43);
        eat(col);
        applyStimulus("pellet_pair", col, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus("pellet_repeat", col, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        col = (44'd1 << 0) | (44'd1 << 5) | (44'd1 << 6) | (44'd1 << 7);
        eat(col);
        applyStimulus("pellet_multi", col, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkCount++;
            if (o !== e.snap) $display("[TB] FAIL %s: got st=%0d blk=%h fr=%b sc=%0d flags=%b, expected st=%0d blk=%h fr=%b sc=%0d flags=%b", e.name, o.st, o.blk, o.fr, o.sc, {o.pw, o.pwin, o.gwin, o.rp}, e.snap.st, e.snap.blk, e.snap.fr, e.snap.sc, {e.snap.pw, e.snap.pwin, e.snap.gwin, e.snap.rp});
            else passCount++;
        end
    endtask

    task automatic test_power();
        entry_t e;
        snap_t  o;
        mState = 3'd2;
        mFruit = 3'b101;
        applyStimulus("power_enter", '0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus("power_tick1", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        applyStimulus("power_tick2", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        mState = 3'd1;
        applyStimulus("power_expire", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        mFruit = 3'b111;
        applyStimulus("respawn_fruit1", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkCount++;
            if (o !== e.snap) $display("[TB] FAIL %s: got st=%0d blk=%h fr=%b sc=%0d flags=%b, expected st=%0d blk=%h fr=%b sc=%0d flags=%b", e.name, o.st, o.blk, o.fr, o.sc, {o.pw, o.pwin, o.gwin, o.rp}, e.snap.st, e.snap.blk, e.snap.fr, e.snap.sc, {e.snap.pw, e.snap.pwin, e.snap.gwin, e.snap.rp});
            else passCount++;
        end
    endtask

    task automatic test_fruit_priority();
        entry_t e;
        snap_t  o;
        mState = 3'd2;
        mFruit = 3'b110;
        applyStimulus("fruit_both", '0, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0);
        applyStimulus("both_tick1", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        applyStimulus("both_tick2", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        mState = 3'd1;
        applyStimulus("both_tick3", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        mFruit = 3'b111;
        applyStimulus("both_tick4", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        mFruit = 3'b011;
        applyStimulus("ghost_fruit", '0, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus($sformatf("ghost_tick%0d", i), '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        end
        mFruit = 3'b111;
        applyStimulus("ghost_tick4", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkCount++;
            if (o !== e.snap) $display("[TB] FAIL %s: got st=%0d blk=%h fr=%b sc=%0d flags=%b, expected st=%0d blk=%h fr=%b sc=%0d flags=%b", e.name, o.st, o.blk, o.fr, o.sc, {o.pw, o.pwin, o.gwin, o.rp}, e.snap.st, e.snap.blk, e.snap.fr, e.snap.sc, {e.snap.pw, e.snap.pwin, e.snap.gwin, e.snap.rp});
            else passCount++;
        end
    endtask

    task automatic test_power_reload();
        entry_t e;
        snap_t  o;
        mState = 3'd2;
        mFruit = 3'b110;
        applyStimulus("reload_enter", '0, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus("reload_t1", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        applyStimulus("reload_t2", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        mFruit = 3'b010;
        applyStimulus("reload_hit", '0, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0);
        applyStimulus("reload_t3", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        mFruit = 3'b011;
        applyStimulus("reload_t4", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        mState = 3'd1;
        applyStimulus("reload_t5", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        mFruit = 3'b111;
        applyStimulus("reload_t6", '0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkCount++;
            if (o !== e.snap) $display("[TB] FAIL %s: got st=%0d blk=%h fr=%b sc=%0d flags=%b, expected st=%0d blk=%h fr=%b sc=%0d flags=%b", e.name, o.st, o.blk, o.fr, o.sc, {o.pw, o.pwin, o.gwin, o.rp}, e.snap.st, e.snap.blk, e.snap.fr, e.snap.sc, {e.snap.pw, e.snap.pwin, e.snap.gwin, e.snap.rp});
            else passCount++;
        end
    endtask

    task automatic test_ghost_win();
        entry_t      e;
        snap_t       o;
        logic [43:0] col;
        col = ~(44'd1 << 20);
        eat(col);
        applyStimulus("pellets_43", col, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        col = 44'd1 << 20;
        eat(col);
        mState = 3'd4;
        applyStimulus("ghost_beats_last", col, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus("ghost_frozen", '1, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1);
        modelReset();
        applyStimulus("ghost_restart", '0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        applyStimulus("idle_ignores", '1, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkCount++;
            if (o !== e.snap) $display("[TB] FAIL %s: got st=%0d blk=%h fr=%b sc=%0d flags=%b, expected st=%0d blk=%h fr=%b sc=%0d flags=%b", e.name, o.st, o.blk, o.fr, o.sc, {o.pw, o.pwin, o.gwin, o.rp}, e.snap.st, e.snap.blk, e.snap.fr, e.snap.sc, {e.snap.pw, e.snap.pwin, e.snap.gwin, e.snap.rp});
            else passCount++;
        end
    endtask

    task automatic test_pac_win();
        entry_t e;
        snap_t  o;
        mState  = 3'd1;
        mRstPos = 1'b1;
        applyStimulus("restart", '0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        mRstPos = 1'b0;
        eat('1);
        mState = 3'd3;
        applyStimulus("all_pellets", '1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        modelReset();
        applyStimulus("pacwin_restart", '0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkCount++;
            if (o !== e.snap) $display("[TB] FAIL %s: got st=%0d blk=%h fr=%b sc=%0d flags=%b, expected st=%0d blk=%h fr=%b sc=%0d flags=%b", e.name, o.st, o.blk, o.fr, o.sc, {o.pw, o.pwin, o.gwin, o.rp}, e.snap.st, e.snap.blk, e.snap.fr, e.snap.sc, {e.snap.pw, e.snap.pwin, e.snap.gwin, e.snap.rp});
            else passCount++;
        end
    endtask

    task automatic test_power_win_and_reset();
        entry_t e;
        snap_t  o;
        mState  = 3'd1;
        mRstPos = 1'b1;
        applyStimulus("round3", '0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        mRstPos = 1'b0;
        mState  = 3'd2;
        mFruit  = 3'b101;
        applyStimulus("power_again", '0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
        mState = 3'd3;
        applyStimulus("power_beats_ghost", '0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus("pacwin_frozen", '1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        modelReset();
        applyStimulus("pacwin_restart2", '0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        mState  = 3'd1;
        mRstPos = 1'b1;
        applyStimulus("round4", '0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        mRstPos = 1'b0;
        mState  = 3'd2;
        mFruit  = 3'b110;
        eat(44'd1 << 10);
        applyStimulus("power_midround", 44'd1 << 10, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
        #2;
        rst   = 1'b0;
        start = 1'b1;
        #1;
        modelReset();
        expQ.push_back('{"async_reset", model()});
        obsQ.push_back(observe());
        #1;
        rst = 1'b1;
        mState  = 3'd1;
        mRstPos = 1'b1;
        applyStimulus("start_after_reset", '0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkCount++;
            if (o !== e.snap) $display("[TB] FAIL %s: got st=%0d blk=%h fr=%b sc=%0d flags=%b, expected st=%0d blk=%h fr=%b sc=%0d flags=%b", e.name, o.st, o.blk, o.fr, o.sc, {o.pw, o.pwin, o.gwin, o.rp}, e.snap.st, e.snap.blk, e.snap.fr, e.snap.sc, {e.snap.pw, e.snap.pwin, e.snap.gwin, e.snap.rp});
            else passCount++;
        end
    endtask

    initial begin
        rst                  = 1'b0;
        start                = 1'b0;
        tick                 = 1'b0;
        collision            = '0;
        fruitCollisionPacman = '0;
        fruitCollisionGhost  = '0;
        PlayerCollision      = 1'b0;
        modelReset();
        test_reset();
        test_start();
        test_pellets();
        test_power();
        test_fruit_priority();
        test_power_reload();
        test_ghost_win();
        test_pac_win();
        test_power_win_and_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
